// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer encodings, master IDs, response codes and
// the master-select decode used by every 3:1 mux in this block.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    MST_M1   = 2'b00,
    MST_M2   = 2'b01,
    MST_M3   = 2'b10,
    MST_NONE = 2'b11
  } mst_id_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // One-hot decode of a master ID; MST_NONE selects nothing.
  function automatic logic [2:0] mst_sel(input logic [1:0] id);
    case (id)
      MST_M1:  return 3'b001;
      MST_M2:  return 3'b010;
      MST_M3:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // NONSEQ and SEQ carry a real data phase; IDLE and BUSY do not.
  function automatic logic is_real_trans(input logic [1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_master_mux_if.sv
// Bus bundle around the master mux. The "slave" modport is the mux itself
// (it receives the masters' signals); the "master" modport is everything
// around it: the three masters, the arbiter and the shared slave.
// Handshake: a transfer phase completes on a rising hclk edge where
// hready=1; with hready=0 every phase (address and data) is stretched and
// the data-phase owner does not change.
interface ahb_master_mux_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]        hmaster;
  logic [ADDR_W-1:0] haddr1, haddr2, haddr3;
  logic [1:0]        htrans1, htrans2, htrans3;
  logic              hwrite1, hwrite2, hwrite3;
  logic [2:0]        hsize1, hsize2, hsize3;
  logic [2:0]        hburst1, hburst2, hburst3;
  logic [DATA_W-1:0] hwdata1, hwdata2, hwdata3;
  logic              hready;
  logic              hresp;
  logic [DATA_W-1:0] hrdata_s;

  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hready_m;
  logic              hresp_m;
  logic [1:0]        hmaster_dp;
  logic              dp_active;
  logic              hdone1, hdone2, hdone3;

  modport slave (
    input  hmaster,
    input  haddr1, haddr2, haddr3, htrans1, htrans2, htrans3,
    input  hwrite1, hwrite2, hwrite3, hsize1, hsize2, hsize3,
    input  hburst1, hburst2, hburst3, hwdata1, hwdata2, hwdata3,
    input  hready, hresp, hrdata_s,
    output haddr, htrans, hwrite, hsize, hburst, hwdata,
    output hrdata, hready_m, hresp_m, hmaster_dp, dp_active,
    output hdone1, hdone2, hdone3
  );

  modport master (
    output hmaster,
    output haddr1, haddr2, haddr3, htrans1, htrans2, htrans3,
    output hwrite1, hwrite2, hwrite3, hsize1, hsize2, hsize3,
    output hburst1, hburst2, hburst3, hwdata1, hwdata2, hwdata3,
    output hready, hresp, hrdata_s,
    input  haddr, htrans, hwrite, hsize, hburst, hwdata,
    input  hrdata, hready_m, hresp_m, hmaster_dp, dp_active,
    input  hdone1, hdone2, hdone3
  );
endinterface

// File: rtl/ahb_mux3.sv
// Width-parameterised 3:1 mux keyed by a master ID; ID 2'b11 gives zero.
module ahb_mux3
  import ahb_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [1:0]   sel_i,
  input  logic [W-1:0] d0_i,
  input  logic [W-1:0] d1_i,
  input  logic [W-1:0] d2_i,
  output logic [W-1:0] y_o
);

  logic [2:0] oh;

  // AND-OR select so the unselected/none case is naturally all-zero.
  always_comb begin
    oh  = mst_sel(sel_i);
    y_o = ({W{oh[0]}} & d0_i) | ({W{oh[1]}} & d1_i) | ({W{oh[2]}} & d2_i);
  end

endmodule

// File: rtl/ahb_master_mux.sv
// AHB master-side mux behind the arbiter. Address/control follow hmaster
// directly; write data follows a data-phase copy of hmaster that advances
// only on hready, keeping hwdata aligned with the pipelined address phase.
module ahb_master_mux
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          hclk,
  input  logic          hresetn,
  ahb_master_mux_if.slave bus
);

  localparam int CTRL_W = ADDR_W + 2 + 1 + 3 + 3;

  logic [CTRL_W-1:0] ctrl1, ctrl2, ctrl3, ctrl_bus;
  logic [DATA_W-1:0] wdata_sel;

  logic [1:0] hmaster_dp_q, hmaster_dp_d;
  logic       dp_active_q, dp_active_d;
  logic       dp_write_q, dp_write_d;
  logic [2:0] hdone_q, hdone_d;

  assign ctrl1 = {bus.haddr1, bus.htrans1, bus.hwrite1, bus.hsize1, bus.hburst1};
  assign ctrl2 = {bus.haddr2, bus.htrans2, bus.hwrite2, bus.hsize2, bus.hburst2};
  assign ctrl3 = {bus.haddr3, bus.htrans3, bus.hwrite3, bus.hsize3, bus.hburst3};

  ahb_mux3 #(.W(CTRL_W)) u_ctrl_mux (
    .sel_i (bus.hmaster),
    .d0_i  (ctrl1),
    .d1_i  (ctrl2),
    .d2_i  (ctrl3),
    .y_o   (ctrl_bus)
  );

  assign {bus.haddr, bus.htrans, bus.hwrite, bus.hsize, bus.hburst} = ctrl_bus;

  ahb_mux3 #(.W(DATA_W)) u_wdata_mux (
    .sel_i (hmaster_dp_q),
    .d0_i  (bus.hwdata1),
    .d1_i  (bus.hwdata2),
    .d2_i  (bus.hwdata3),
    .y_o   (wdata_sel)
  );

  // Write data is only driven during a real write data phase.
  assign bus.hwdata = (dp_active_q && dp_write_q) ? wdata_sel : '0;

  assign bus.hrdata   = bus.hrdata_s;
  assign bus.hready_m = bus.hready;
  assign bus.hresp_m  = bus.hresp;

  assign bus.hmaster_dp = hmaster_dp_q;
  assign bus.dp_active  = dp_active_q;
  assign bus.hdone1     = hdone_q[0];
  assign bus.hdone2     = hdone_q[1];
  assign bus.hdone3     = hdone_q[2];

  // Data-phase next state: advance on hready, flag OKAY completions.
  always_comb begin
    hmaster_dp_d = hmaster_dp_q;
    dp_active_d  = dp_active_q;
    dp_write_d   = dp_write_q;
    hdone_d      = {3{bus.hready & dp_active_q & (bus.hresp == HRESP_OKAY)}}
                   & mst_sel(hmaster_dp_q);
    if (bus.hready) begin
      hmaster_dp_d = bus.hmaster;
      dp_active_d  = is_real_trans(bus.htrans);
      dp_write_d   = bus.hwrite;
    end
  end

  // Data-phase state registers with asynchronous reset.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      hmaster_dp_q <= MST_M1;
      dp_active_q  <= 1'b0;
      dp_write_q   <= 1'b0;
      hdone_q      <= 3'b000;
    end else begin
      hmaster_dp_q <= hmaster_dp_d;
      dp_active_q  <= dp_active_d;
      dp_write_q   <= dp_write_d;
      hdone_q      <= hdone_d;
    end
  end

endmodule

// File: tb/tb_ahb_master_mux.sv
// Bench for ahb_master_mux: directed scenarios then random traffic, all
// outputs compared each cycle against a transfer-level reference model.
module tb_ahb_master_mux;

  logic hclk;
  logic hresetn;

  ahb_master_mux_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ahb_master_mux #(.ADDR_W(32), .DATA_W(32)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  // Clock
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Per-master stimulus, indexed 0..2 for M1..M3
  logic [31:0] addr_m [3];
  logic [1:0]  trans_m[3];
  logic        wr_m   [3];
  logic [2:0]  size_m [3];
  logic [2:0]  burst_m[3];
  logic [31:0] wdata_m[3];
  logic [1:0]  hmaster;
  logic        hready, hresp;
  logic [31:0] hrdata_s;

  assign bus.hmaster  = hmaster;
  assign bus.haddr1   = addr_m[0];
  assign bus.haddr2   = addr_m[1];
  assign bus.haddr3   = addr_m[2];
  assign bus.htrans1  = trans_m[0];
  assign bus.htrans2  = trans_m[1];
  assign bus.htrans3  = trans_m[2];
  assign bus.hwrite1  = wr_m[0];
  assign bus.hwrite2  = wr_m[1];
  assign bus.hwrite3  = wr_m[2];
  assign bus.hsize1   = size_m[0];
  assign bus.hsize2   = size_m[1];
  assign bus.hsize3   = size_m[2];
  assign bus.hburst1  = burst_m[0];
  assign bus.hburst2  = burst_m[1];
  assign bus.hburst3  = burst_m[2];
  assign bus.hwdata1  = wdata_m[0];
  assign bus.hwdata2  = wdata_m[1];
  assign bus.hwdata3  = wdata_m[2];
  assign bus.hready   = hready;
  assign bus.hresp    = hresp;
  assign bus.hrdata_s = hrdata_s;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the transfer accepted into the data phase, and which
  // master (1..3, 0 = none) completed OKAY on the previous edge.
  int   m_owner;
  bit   m_real;
  bit   m_wr;
  int   m_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_real  = 0;
    m_wr    = 0;
    m_done  = 0;
  endtask

  // Edge behaviour: a data phase finishes when hready is high; the address
  // phase currently on the bus then becomes the new data phase.
  task automatic model_edge();
    int o;
    o = int'(hmaster);
    m_done = (hready && m_real && !hresp) ? m_owner + 1 : 0;
    if (hready) begin
      m_owner = o;
      m_real  = (o < 3) && (trans_m[o < 3 ? o : 0] inside {2'b10, 2'b11});
      m_wr    = (o < 3) && wr_m[o < 3 ? o : 0];
    end
  endtask

  task automatic check_all();
    int          o;
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_trans;
    logic        e_wr;
    logic [2:0]  e_size, e_burst;
    o = int'(hmaster);
    if (o < 3) begin
      e_addr = addr_m[o]; e_trans = trans_m[o]; e_wr = wr_m[o];
      e_size = size_m[o]; e_burst = burst_m[o];
    end else begin
      e_addr = '0; e_trans = 2'b00; e_wr = 1'b0; e_size = '0; e_burst = '0;
    end
    e_wdata = (m_real && m_wr && m_owner < 3) ? wdata_m[m_owner < 3 ? m_owner : 0] : 32'h0;
    chk("haddr",      64'(bus.haddr),      64'(e_addr));
    chk("htrans",     64'(bus.htrans),     64'(e_trans));
    chk("hwrite",     64'(bus.hwrite),     64'(e_wr));
    chk("hsize",      64'(bus.hsize),      64'(e_size));
    chk("hburst",     64'(bus.hburst),     64'(e_burst));
    chk("hwdata",     64'(bus.hwdata),     64'(e_wdata));
    chk("hrdata",     64'(bus.hrdata),     64'(hrdata_s));
    chk("hready_m",   64'(bus.hready_m),   64'(hready));
    chk("hresp_m",    64'(bus.hresp_m),    64'(hresp));
    chk("hmaster_dp", 64'(bus.hmaster_dp), 64'(m_owner));
    chk("dp_active",  64'(bus.dp_active),  64'(m_real));
    chk("hdone1",     64'(bus.hdone1),     64'(m_done == 1));
    chk("hdone2",     64'(bus.hdone2),     64'(m_done == 2));
    chk("hdone3",     64'(bus.hdone3),     64'(m_done == 3));
  endtask

  // One bus cycle: inputs are set by the caller just after a falling edge,
  // outputs checked 1 time unit later, model advanced at the rising edge.
  task automatic step();
    if (!hresetn) model_reset();
    #1;
    check_all();
    @(posedge hclk);
    if (hresetn) model_edge();
    @(negedge hclk);
  endtask

  task automatic set_master(input int i, input logic [31:0] a, input logic [1:0] t,
                            input logic w, input logic [31:0] d);
    addr_m[i] = a; trans_m[i] = t; wr_m[i] = w; wdata_m[i] = d;
    size_m[i] = 3'b010; burst_m[i] = 3'b000;
  endtask

  initial begin
    // Reset with no master selected
    hresetn = 1'b0;
    hmaster = 2'b11; hready = 1'b1; hresp = 1'b0; hrdata_s = 32'h0;
    for (int i = 0; i < 3; i++) set_master(i, 32'h0, 2'b00, 1'b0, 32'h0);
    model_reset();
    @(negedge hclk);
    step();
    step();
    hresetn = 1'b1;
    step();

    // Single write by M1
    set_master(0, 32'h1000, 2'b10, 1'b1, 32'hA5A5A5A5);
    hmaster = 2'b00; hrdata_s = 32'h1234_5678;
    step();
    hmaster = 2'b11;
    step();
    step();
    step();

    // Handover to M2 while the M1 write data phase is stalled
    set_master(0, 32'h1100, 2'b10, 1'b1, 32'h1111_1111);
    set_master(1, 32'h2000, 2'b10, 1'b1, 32'h2222_2222);
    hmaster = 2'b00;
    step();
    hmaster = 2'b01; hready = 1'b0;
    step();
    step();
    hready = 1'b1;
    step();
    hmaster = 2'b11;
    step();
    step();

    // Pipelined handovers M1 -> M2 -> M3
    for (int i = 0; i < 3; i++) set_master(i, 32'h3000 + 32'(i), 2'b10, 1'b1, 32'(i + 1));
    for (int i = 0; i < 3; i++) begin
      hmaster = 2'(i);
      step();
    end
    hmaster = 2'b11;
    step();
    step();
    step();

    // M2 BUSY then IDLE: no real data phase
    set_master(1, 32'h4000, 2'b01, 1'b1, 32'hDEAD_BEEF);
    hmaster = 2'b01;
    step();
    trans_m[1] = 2'b00;
    step();
    hmaster = 2'b11;
    step();
    step();

    // M3 data phase completing with ERROR
    set_master(2, 32'h5000, 2'b10, 1'b1, 32'h3333_3333);
    hmaster = 2'b10;
    step();
    hmaster = 2'b11; hresp = 1'b1;
    step();
    hresp = 1'b0;
    step();
    step();

    // Random traffic with a reset asserted mid-transfer
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        addr_m[i]  = $urandom;
        trans_m[i] = 2'($urandom_range(0, 3));
        wr_m[i]    = 1'($urandom_range(0, 1));
        size_m[i]  = 3'($urandom_range(0, 7));
        burst_m[i] = 3'($urandom_range(0, 7));
        wdata_m[i] = $urandom;
      end
      hmaster  = 2'($urandom_range(0, 3));
      hready   = ($urandom_range(0, 3) != 0);
      hresp    = ($urandom_range(0, 7) == 0);
      hrdata_s = $urandom;
      if (n == 200) hresetn = 1'b0;
      if (n == 202) hresetn = 1'b1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_master_mux.md
Name: ahb_master_mux

Overview:
- Sits directly downstream of the bus arbiter.
- Consumes the arbiter's registered hmaster and steers the three masters' address/control and write data onto the shared AHB bus.
- The address phase follows hmaster. The data phase follows a registered copy of hmaster that advances only on hready, so write data stays aligned with the pipelined address phase across master handovers.
- Also returns the shared slave response to the masters and emits per-master transfer-complete pulses.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
hclk  in  1  bus clock
hresetn  in  1  reset, asynchronous, active-low
hmaster  in  2  address-phase owner from arbiter (00=M1, 01=M2, 10=M3, 11=none)
haddr1/haddr2/haddr3  in  ADDR_W  master address
htrans1/htrans2/htrans3  in  2  master transfer type
hwrite1/hwrite2/hwrite3  in  1  master write flag
hsize1/hsize2/hsize3  in  3  master transfer size
hburst1/hburst2/hburst3  in  3  master burst type
hwdata1/hwdata2/hwdata3  in  DATA_W  master write data
hready  in  1  shared slave ready
hresp  in  1  shared slave response (0=OKAY, 1=ERROR)
hrdata_s  in  DATA_W  slave read data
haddr  out  ADDR_W  bus address
htrans  out  2  bus transfer type
hwrite  out  1  bus write flag
hsize  out  3  bus size
hburst  out  3  bus burst
hwdata  out  DATA_W  bus write data
hrdata  out  DATA_W  read data to all masters
hready_m  out  1  ready to all masters
hresp_m  out  1  response to all masters
hmaster_dp  out  2  data-phase owner
dp_active  out  1  a real (NONSEQ/SEQ) data phase is in progress
hdone1/hdone2/hdone3  out  1  one-cycle pulse: data phase of that master completed

Behaviour:
- Reset:
  - Asynchronous on hresetn=0; register release is synchronous to hclk.
  - Resets hmaster_dp=2'b00, dp_active=0, dp_write=0, hdone1..3=0.
- Address phase (combinational from hmaster):
  - haddr, htrans, hwrite, hsize, hburst = signals of the selected master.
  - hmaster=2'b11: haddr=0, htrans=IDLE (2'b00), hwrite=0, hsize=0, hburst=0.
- Data-phase register:
  - Updates on posedge hclk only when hready=1:
    - hmaster_dp <= hmaster
    - dp_active <= (selected htrans is NONSEQ or SEQ)
    - dp_write <= selected hwrite
  - hready=0: all data-phase state holds, even if hmaster changes that cycle.
  - IDLE and BUSY transfers set dp_active=0.
- Write data (combinational from hmaster_dp):
  - hwdata = hwdata of the master given by hmaster_dp when dp_active=1 and dp_write=1; otherwise 0.
  - hmaster_dp=2'b11 gives hwdata=0.
- Response path:
  - hrdata=hrdata_s, hready_m=hready, hresp_m=hresp; pure pass-through, zero latency.
- Completion pulses (registered, one cycle late):
  - hdoneN <= (hready & dp_active & hmaster_dp==N-1 & !hresp).
  - A completion with hresp=1 produces no pulse.
- Latency:
  - Address mux: 0 cycles.
  - Write data: selected one hready-qualified edge after its address phase.
  - hdone: 1 cycle after data-phase completion.
- Boundary conditions:
  - Handover while hready=0: the address mux switches immediately; hwdata keeps the old master until hready=1.
  - Back-to-back handovers M1→M2→M3 with hready=1: hwdata source lags hmaster by exactly one cycle.
  - Reset asserted mid-transfer: all outputs driven from registers go to reset values at once; mux outputs follow their inputs.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS encodings: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - Master IDs: M1=2'b00, M2=2'b01, M3=2'b10, NONE=2'b11.
  - HRESP: OKAY=0, ERROR=1.
  - The 3-master select function.
- One sub-module, ahb_mux3: a width-parameterised 3:1 mux with a zero default for select 2'b11. Instantiate it for the address/control bundle and for hwdata.

Test Plan:
1. Reset: hresetn=0 mid-cycle → hmaster_dp=00, dp_active=0, hdone1..3=0 immediately; hmaster=11 → htrans=00, haddr=0.
2. Single write: hmaster=00, haddr1=0x1000, htrans1=NONSEQ, hwrite1=1, hwdata1=0xA5A5A5A5, hready=1 → next cycle hmaster_dp=00, dp_active=1, hwdata=0xA5A5A5A5; following cycle hdone1=1 for exactly one cycle.
3. Handover with wait states: M1 write in data phase, hmaster→01 while hready=0 for 2 cycles → haddr=haddr2 at once; hwdata stays hwdata1 for both wait cycles; hmaster_dp becomes 01 only after hready=1.
4. Pipelined handovers: hready=1, hmaster 00,01,10 on consecutive cycles, all NONSEQ writes with hwdataN=N → hwdata sequence 1,2,3 one cycle behind; hdone1, hdone2, hdone3 pulse on consecutive cycles.
5. IDLE/BUSY: M2 htrans2=BUSY then IDLE → dp_active=0, hwdata=0, no hdone2 pulse.
6. Error: M3 data phase with hresp=1, hready=1 → hresp_m=1 the same cycle, hdone3 stays 0.
